frame_line_meter: RTL and testbench

Measures the line count of the incoming video field from raw HSYNC/VSYNC and reports it once per field as a one-clock `new_frame` pulse with a stable `frame_lines` value. It sits directly upstream of the I2C diagnostic/reporting path and drives the same `new_frame`/`frame_lines` pair that the 240-line diagnostic pattern generator produces, so the two are drop-in interchangeable. It also flags loss of sync.

---
 rtl/frame_line_meter_pkg.sv | 26 ++
 rtl/sync_edge_det.sv | 39 +++
 rtl/frame_line_meter.sv | 155 +++++++++++++++
 tb/tb_frame_line_meter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/frame_line_meter_pkg.sv
// Shared definitions for the field line meter and the diagnostic pattern generator
// that drives the same new_frame/frame_lines pair.
package frame_line_meter_pkg;

    localparam int LINES_W = 10;
    localparam logic [LINES_W-1:0] FLM_DEFAULT_LINES = 10'd240;
    localparam logic [LINES_W-1:0] FLM_LINES_MAX     = 10'd1023;

    typedef enum logic [1:0] {
        FLM_UNARMED = 2'd0,
        FLM_COUNT   = 2'd1,
        FLM_LOST    = 2'd2
    } flm_state_e;

    // Saturating line increment: a runaway field pins at the maximum instead of wrapping.
    function automatic logic [LINES_W-1:0] flm_sat_inc(input logic [LINES_W-1:0] v);
        logic [LINES_W-1:0] r;
        if (v == FLM_LINES_MAX) begin
            r = v;
        end else begin
            r = v + 10'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with polarity normalisation and an active-high leading-edge strobe.
module sync_edge_det #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw_in,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic level_s;

    assign level_s = sync_q ^ ACTIVE_LOW;
    assign rise    = level_s & ~prev_q;

    // Next values for the synchronizer chain and the edge-detect history.
    always_comb begin
        meta_d = raw_in;
        sync_d = meta_q;
        prev_d = level_s;
    end

    // Synchronizer flops reset to the inactive raw level so no edge appears out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= ACTIVE_LOW;
            sync_q <= ACTIVE_LOW;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/frame_line_meter.sv
// Counts HSYNC leading edges between VSYNC leading edges, reports accepted fields with a
// one-clock new_frame pulse and flags loss of VSYNC after a timeout.
module frame_line_meter
    import frame_line_meter_pkg::*;
#(
    parameter int CLK_HZ        = 27000000,
    parameter int HS_ACTIVE_LOW = 1,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int MIN_LINES     = 16,
    parameter int TIMEOUT_MS    = 100,
    parameter int DEFAULT_LINES = int'(FLM_DEFAULT_LINES)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic               new_frame,
    output logic [LINES_W-1:0] frame_lines,
    output logic               signal_lost
);

    localparam int TO_TERM_I = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int TO_W      = $clog2(TO_TERM_I + 1);
    localparam logic [TO_W-1:0]    TO_TERM = TO_W'(TO_TERM_I);
    localparam logic [TO_W-1:0]    TO_ONE  = TO_W'(1'b1);
    localparam logic [LINES_W-1:0] MIN_L   = LINES_W'(MIN_LINES);
    localparam logic [LINES_W-1:0] DEF_L   = LINES_W'(DEFAULT_LINES);

    logic hs_rise_s, vs_rise_s, timeout_s;
    flm_state_e state_q, state_d;
    logic [LINES_W-1:0] line_cnt_q, line_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               new_frame_q, new_frame_d;
    logic [LINES_W-1:0] frame_lines_q, frame_lines_d;
    logic               signal_lost_q, signal_lost_d;

    sync_edge_det #(.ACTIVE_LOW(HS_ACTIVE_LOW != 0)) u_hs_det (
        .clk(clk), .resetn(resetn), .raw_in(hsync_in), .rise(hs_rise_s)
    );

    sync_edge_det #(.ACTIVE_LOW(VS_ACTIVE_LOW != 0)) u_vs_det (
        .clk(clk), .resetn(resetn), .raw_in(vsync_in), .rise(vs_rise_s)
    );

    // Line and timeout counters; an HSYNC coinciding with VSYNC opens the new field at 1.
    always_comb begin
        if (vs_rise_s) begin
            line_cnt_d = hs_rise_s ? 10'd1 : 10'd0;
        end else if (hs_rise_s) begin
            line_cnt_d = flm_sat_inc(line_cnt_q);
        end else begin
            line_cnt_d = line_cnt_q;
        end
        if (vs_rise_s) begin
            to_cnt_d = {TO_W{1'b0}};
        end else if (to_cnt_q != TO_TERM) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Looking at the next count lets signal_lost rise on the edge the counter saturates.
    assign timeout_s = (to_cnt_d == TO_TERM);

    // Next-state logic.
    always_comb begin
        case (state_q)
            FLM_UNARMED, FLM_COUNT: begin
                if (vs_rise_s) begin
                    state_d = FLM_COUNT;
                end else if (timeout_s) begin
                    state_d = FLM_LOST;
                end else begin
                    state_d = state_q;
                end
            end
            FLM_LOST: begin
                if (vs_rise_s) begin
                    state_d = FLM_COUNT;
                end else begin
                    state_d = FLM_LOST;
                end
            end
            default: state_d = FLM_UNARMED;
        endcase
    end

    // Output logic: only a VSYNC seen while counting can produce a report.
    always_comb begin
        new_frame_d   = 1'b0;
        frame_lines_d = frame_lines_q;
        signal_lost_d = signal_lost_q;
        case (state_q)
            FLM_COUNT: begin
                if (vs_rise_s) begin
                    signal_lost_d = 1'b0;
                    if (line_cnt_q >= MIN_L) begin
                        new_frame_d   = 1'b1;
                        frame_lines_d = line_cnt_q;
                    end else begin
                        frame_lines_d = frame_lines_q;
                    end
                end else if (timeout_s) begin
                    signal_lost_d = 1'b1;
                end else begin
                    signal_lost_d = signal_lost_q;
                end
            end
            FLM_UNARMED, FLM_LOST: begin
                if (vs_rise_s) begin
                    signal_lost_d = 1'b0;
                end else if (timeout_s) begin
                    signal_lost_d = 1'b1;
                end else begin
                    signal_lost_d = signal_lost_q;
                end
            end
            default: begin
                signal_lost_d = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FLM_UNARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line_cnt_q    <= {LINES_W{1'b0}};
            to_cnt_q      <= {TO_W{1'b0}};
            new_frame_q   <= 1'b0;
            frame_lines_q <= DEF_L;
            signal_lost_q <= 1'b1;
        end else begin
            line_cnt_q    <= line_cnt_d;
            to_cnt_q      <= to_cnt_d;
            new_frame_q   <= new_frame_d;
            frame_lines_q <= frame_lines_d;
            signal_lost_q <= signal_lost_d;
        end
    end

    assign new_frame   = new_frame_q;
    assign frame_lines = frame_lines_q;
    assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_frame_line_meter.sv
// Directed bench for frame_line_meter: table of fields plus hand sequences for
// simultaneous edges, sync loss/recovery and mid-field reset.
module tb_frame_line_meter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       hsync_in;
    logic       vsync_in;
    logic       new_frame;
    logic [9:0] frame_lines;
    logic       signal_lost;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    bit prev_nf = 1'b0;

    // 100 kHz model clock with 100 ms timeout -> 10000-cycle timeout.
    frame_line_meter #(
        .CLK_HZ(100000), .HS_ACTIVE_LOW(1), .VS_ACTIVE_LOW(1),
        .MIN_LINES(16), .TIMEOUT_MS(100), .DEFAULT_LINES(240)
    ) dut (
        .clk(clk), .resetn(resetn), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .new_frame(new_frame), .frame_lines(frame_lines), .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count report pulses and require each to last a single cycle.
    always @(negedge clk) begin
        if (new_frame === 1'b1) begin
            pulse_cnt++;
            chk("pulse_width", int'(prev_nf), 0);
        end
        prev_nf = (new_frame === 1'b1);
    end

    // Each line: HSYNC low 2 clocks, high 2 clocks. Called #1 after a posedge.
    task automatic send_lines(input int n);
        for (int i = 0; i < n; i++) begin
            hsync_in = 1'b0;
            repeat (2) @(posedge clk);
            #1 hsync_in = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    // Drive a VSYNC leading edge (optionally with an HSYNC) and sample new_frame
    // one cycle early and at the expected 3-clock latency.
    task automatic vsync_edge(input bit with_hs, output int early, output int at);
        vsync_in = 1'b0;
        if (with_hs) hsync_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        early = int'(new_frame);
        @(posedge clk);
        @(negedge clk);
        at = int'(new_frame);
        @(posedge clk);
        #1;
        vsync_in = 1'b1;
        hsync_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int lines;
        int exp_pulse;
        int exp_lines;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int early, at, p0, n;

        vecs[0] = '{50,   0, 240};
        vecs[1] = '{262,  1, 262};
        vecs[2] = '{262,  1, 262};
        vecs[3] = '{240,  1, 240};
        vecs[4] = '{5,    0, 240};
        vecs[5] = '{240,  1, 240};
        vecs[6] = '{15,   0, 240};
        vecs[7] = '{16,   1, 16};
        vecs[8] = '{1100, 1, 1023};
        vecs[9] = '{17,   1, 17};

        resetn   = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_new_frame", int'(new_frame), 0);
        chk("reset_frame_lines", int'(frame_lines), 240);
        chk("reset_signal_lost", int'(signal_lost), 1);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 10; v++) begin
            send_lines(vecs[v].lines);
            p0 = pulse_cnt;
            vsync_edge(1'b0, early, at);
            chk($sformatf("vec%0d_early", v), early, 0);
            chk($sformatf("vec%0d_pulse_at_lat", v), at, vecs[v].exp_pulse);
            chk($sformatf("vec%0d_pulse_count", v), pulse_cnt - p0, vecs[v].exp_pulse);
            chk($sformatf("vec%0d_frame_lines", v), int'(frame_lines), vecs[v].exp_lines);
            chk($sformatf("vec%0d_signal_lost", v), int'(signal_lost), 0);
        end

        // HSYNC and VSYNC together: that HSYNC belongs to the next field.
        send_lines(240);
        p0 = pulse_cnt;
        vsync_edge(1'b1, early, at);
        chk("simul_pulse", at, 1);
        chk("simul_frame_lines", int'(frame_lines), 240);
        send_lines(19);
        vsync_edge(1'b0, early, at);
        chk("simul_next_pulse", at, 1);
        chk("simul_next_lines", int'(frame_lines), 20);
        chk("simul_pulse_count", pulse_cnt - p0, 2);

        // Sync loss: no VSYNC for longer than the timeout.
        p0 = pulse_cnt;
        repeat (9900) @(posedge clk);
        #1;
        chk("lost_not_early", int'(signal_lost), 0);
        n = 0;
        while (signal_lost !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lost_asserted", int'(signal_lost), 1);
        chk("lost_lines_held", int'(frame_lines), 20);
        chk("lost_no_pulse", pulse_cnt - p0, 0);

        // Recovery: first VSYNC only re-arms, second reports.
        send_lines(40);
        vsync_edge(1'b0, early, at);
        chk("recover_first_pulse", at, 0);
        chk("recover_signal_lost", int'(signal_lost), 0);
        chk("recover_lines_held", int'(frame_lines), 20);
        send_lines(100);
        vsync_edge(1'b0, early, at);
        chk("recover_second_pulse", at, 1);
        chk("recover_second_lines", int'(frame_lines), 100);

        // Mid-field reset aborts the count and disarms.
        send_lines(100);
        resetn = 1'b0;
        #1;
        chk("midrst_new_frame", int'(new_frame), 0);
        chk("midrst_frame_lines", int'(frame_lines), 240);
        chk("midrst_signal_lost", int'(signal_lost), 1);
        @(posedge clk);
        #1 resetn = 1'b1;
        p0 = pulse_cnt;
        send_lines(30);
        vsync_edge(1'b0, early, at);
        chk("midrst_first_pulse", at, 0);
        chk("midrst_first_count", pulse_cnt - p0, 0);
        chk("midrst_first_lines", int'(frame_lines), 240);
        send_lines(30);
        vsync_edge(1'b0, early, at);
        chk("midrst_second_pulse", at, 1);
        chk("midrst_second_lines", int'(frame_lines), 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
